// File: rtl/mux41_scan_pkg.sv
// Shared definitions for the 4:1 mux scan controller: state encodings,
// default settle time and channel count.
package mux41_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int SETTLE_DEF = 1;
    localparam int NUM_CH     = 4;
    localparam logic [1:0] LAST_CH = 2'(NUM_CH - 1);

endpackage

// File: rtl/mux41_settle_timer.sv
// Dwell down-counter: loads cnt_init, counts down to zero and holds there.
module mux41_settle_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] cnt_init,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= cnt_init;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mux41_scan_ctrl.sv
// Walks the 4:1 mux selects 0..3, samples f on each after a settle dwell and
// hands the 4-bit snapshot out over valid/ready. SCAN_PARITY_EN adds port par.
module mux41_scan_ctrl
    import mux41_scan_pkg::*;
#(
    parameter int SETTLE = SETTLE_DEF,
    parameter int CNT_W  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       f,
    input  logic       ready,
    output logic       s0,
    output logic       s1,
    output logic [3:0] snap,
    output logic       valid,
`ifdef SCAN_PARITY_EN
    output logic       par,
`endif
    output logic       busy
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE - 1);

    state_t     state, state_nxt;
    logic [1:0] ch;
    logic [1:0] sel;
    logic [2:0] snap_sh;
    logic       zero;
    logic       load;
    logic       restart;
    logic       sample;
    logic       handshake;

    mux41_settle_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .cnt_init (CNT_INIT),
        .zero     (zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        restart   = 1'b0;
        sample    = 1'b0;
        handshake = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_nxt = ST_SCAN;
                    load      = 1'b1;
                    restart   = 1'b1;
                end
            end
            ST_SCAN: begin
                if (zero) begin
                    sample = 1'b1;
                    if (ch == LAST_CH) state_nxt = ST_DONE;
                    else               load      = 1'b1;
                end
            end
            ST_DONE: begin
                if (valid && ready) begin
                    handshake = 1'b1;
                    // A start on the handshake edge chains straight into the next scan.
                    if (start) begin
                        state_nxt = ST_SCAN;
                        load      = 1'b1;
                        restart   = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch      <= '0;
            sel     <= '0;
            snap_sh <= '0;
            snap    <= '0;
            valid   <= 1'b0;
`ifdef SCAN_PARITY_EN
            par     <= 1'b0;
`endif
        end else begin
            if (handshake) begin
                valid <= 1'b0;
                sel   <= '0;
            end
            if (restart) begin
                ch  <= '0;
                sel <= '0;
            end
            if (sample) begin
                if (ch != LAST_CH) begin
                    snap_sh[ch] <= f;
                    ch          <= ch + 2'd1;
                    sel         <= ch + 2'd1;
                end else begin
                    snap  <= {f, snap_sh};
                    valid <= 1'b1;
`ifdef SCAN_PARITY_EN
                    par   <= f ^ (^snap_sh);
`endif
                end
            end
        end
    end

    assign s0   = sel[0];
    assign s1   = sel[1];
    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mux41_scan_ctrl.sv
// Bench for mux41_scan_ctrl: two instances (SETTLE=1 and SETTLE=3), f driven
// from a per-instance word w, expected snapshots queued at start.
module tb_mux41_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start [2];
    logic       ready [2];
    logic       f     [2];
    logic       s0    [2];
    logic       s1    [2];
    logic [3:0] snap  [2];
    logic       valid [2];
    logic       busy  [2];
    logic       par   [2];
    logic [3:0] w     [2];
    logic [3:0] exp_q [$];
    logic [3:0] last_snap [2];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    for (genvar i = 0; i < 2; i++) begin : g_dut
        assign f[i] = w[i][{s1[i], s0[i]}];
        mux41_scan_ctrl #(.SETTLE(i == 0 ? 1 : 3), .CNT_W(4)) u_dut (
            .clk   (clk),
            .rst   (rst),
            .start (start[i]),
            .f     (f[i]),
            .ready (ready[i]),
            .s0    (s0[i]),
            .s1    (s1[i]),
            .snap  (snap[i]),
            .valid (valid[i]),
`ifdef SCAN_PARITY_EN
            .par   (par[i]),
`endif
            .busy  (busy[i])
        );
`ifndef SCAN_PARITY_EN
        assign par[i] = 1'b0;
`endif
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int settle_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk_zero(input int d, input string tag);
        chk({tag, "_sel"},   {s1[d], s0[d]}, 0);
        chk({tag, "_snap"},  snap[d], 0);
        chk({tag, "_valid"}, valid[d], 0);
        chk({tag, "_busy"},  busy[d], 0);
`ifdef SCAN_PARITY_EN
        chk({tag, "_par"},   par[d], 0);
`endif
    endtask

    // Called right after the start edge (pulse=0) or issues the start itself.
    // poke drives start for one edge mid-scan; it must have no effect.
    task automatic do_scan(input int d, input logic [3:0] wv, input bit pulse, input bit poke);
        logic [3:0] e;
        int s;
        s = settle_of(d);
        w[d] = wv;
        exp_q.push_back(wv);
        if (pulse) begin
            start[d] = 1'b1;
            tick();
        end
        start[d] = 1'b0;
        for (int k = 0; k < 4 * s; k++) begin
            chk("scan_sel",   {s1[d], s0[d]}, k / s);
            chk("scan_valid", valid[d], 0);
            chk("scan_busy",  busy[d], 1);
            start[d] = (poke && k == 1);
            tick();
            start[d] = 1'b0;
        end
        e = exp_q.pop_front();
        chk("done_valid", valid[d], 1);
        chk("done_sel",   {s1[d], s0[d]}, 3);
        chk("done_snap",  snap[d], e);
`ifdef SCAN_PARITY_EN
        chk("done_par",   par[d], ^e);
`endif
        last_snap[d] = e;
    endtask

    task automatic handshake(input int d, input int nwait, input bit b2b, input logic [3:0] w2);
        ready[d] = 1'b0;
        for (int k = 0; k < nwait; k++) begin
            tick();
            chk("stall_valid", valid[d], 1);
            chk("stall_snap",  snap[d], last_snap[d]);
            chk("stall_busy",  busy[d], 1);
        end
        ready[d] = 1'b1;
        start[d] = b2b;
        tick();
        ready[d] = 1'b0;
        chk("hs_valid", valid[d], 0);
        chk("hs_sel",   {s1[d], s0[d]}, 0);
        chk("hs_busy",  busy[d], b2b);
        chk("hs_snap",  snap[d], last_snap[d]);
        if (b2b) begin
            do_scan(d, w2, 1'b0, 1'b1);
            handshake(d, 0, 1'b0, 4'd0);
        end else begin
            tick();
            chk("idle_busy", busy[d], 0);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            ready[i] = 1'b0;
            w[i]     = 4'd0;
            last_snap[i] = 4'd0;
        end
        tick();
        tick();
        chk_zero(0, "rst0");
        chk_zero(1, "rst1");
        rst = 1'b0;
        tick();

        // SETTLE=1, one select per cycle, ready held high
        ready[0] = 1'b1;
        do_scan(0, 4'b1010, 1'b1, 1'b0);
        handshake(0, 0, 1'b0, 4'd0);

        // reset mid-scan at ch=2, snapshot from earlier scan must vanish
        w[0] = 4'b1111;
        start[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        tick();
        tick();
        chk("pre_rst_sel", {s1[0], s0[0]}, 2);
        #1 rst = 1'b1;
        #1;
        chk_zero(0, "async_rst");
        #1 rst = 1'b0;
        tick();
        chk_zero(0, "post_rst");
        do_scan(0, 4'b1100, 1'b1, 1'b0);
        handshake(0, 0, 1'b0, 4'd0);

        // SETTLE=3
        do_scan(1, 4'b0110, 1'b1, 1'b0);
        handshake(1, 0, 1'b0, 4'd0);

        // backpressure
        do_scan(1, 4'b1001, 1'b1, 1'b0);
        handshake(1, 5, 1'b0, 4'd0);

        // back-to-back with an ignored start poke during the second scan
        do_scan(0, 4'b0101, 1'b1, 1'b0);
        handshake(0, 2, 1'b1, 4'b0111);

        // parity pair (also a plain snapshot check without the macro)
        do_scan(0, 4'b0011, 1'b1, 1'b0);
        handshake(0, 1, 1'b0, 4'd0);
        do_scan(1, 4'b0111, 1'b1, 1'b1);
        handshake(1, 0, 1'b0, 4'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
